// File: rtl/ppc_fetch_unit_if.sv
// rtl/ppc_fetch_unit_if.sv - redirect, memory and instruction-queue signals of the fetch unit
// Vectors are [63:0] with the PowerPC bit 0 (MSB) at index 63.
interface ppc_fetch_unit_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [60:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    input  mem_resp_valid,
    input  mem_resp_data,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    output mem_resp_valid,
    output mem_resp_data,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/ppc_fetch_unit.sv
// rtl/ppc_fetch_unit.sv - single-outstanding doubleword fetcher feeding a registered instruction queue
// PowerPC bit k of a 64-bit value lives at index 63-k.
module ppc_fetch_unit #(
  parameter int          QDEPTH   = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic             clk,
  input logic             rst_n,
  ppc_fetch_unit_if.master bus
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [63:0]   r_pc;
  logic [63:0]   w_pc_nxt;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic [63:0]   r_q_pc   [QDEPTH];
  logic [31:0]   r_q_inst [QDEPTH];

  logic          w_redirect;
  logic [63:0]   w_redirect_pc;
  logic          w_resp;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_inst_valid;
  logic [31:0]   w_word;

  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & ~64'h3;
  assign w_resp        = bus.mem_resp_valid;
  assign w_accept      = (r_state == S_REQ) & bus.mem_req_ready;
  assign w_inst_valid  = (r_count != '0);

  // Responses only count in WAIT; a redirect makes the in-flight word stale.
  assign w_push = (r_state == S_WAIT) & w_resp & ~w_redirect;
  assign w_pop  = w_inst_valid & bus.inst_ready & ~w_redirect;

  assign w_word = r_pc[2] ? bus.mem_resp_data[31:0] : bus.mem_resp_data[63:32];

  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_redirect || (r_count < C_DEPTH)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_redirect) begin
          w_state_nxt = w_accept ? S_DROP : S_REQ;
        end else if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_state_nxt = w_resp ? S_REQ : S_DROP;
        end else if (w_resp) begin
          w_state_nxt = (w_count_nxt < C_DEPTH) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        // The discarded response frees the memory port even if a new redirect lands with it.
        if (w_resp) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redirect) begin
      w_pc_nxt = w_redirect_pc;
    end else if (w_push) begin
      w_pc_nxt = r_pc + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Storage needs no reset: the outputs are gated by inst_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_pc;
      r_q_inst[r_tail] <= w_word;
    end
  end

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_addr  = (r_state == S_REQ) ? r_pc[63:3] : '0;
  assign bus.inst_valid    = w_inst_valid;
  assign bus.inst          = w_inst_valid ? r_q_inst[r_head] : '0;
  assign bus.inst_pc       = w_inst_valid ? r_q_pc[r_head] : '0;

endmodule

// File: tb/tb_ppc_fetch_unit.sv
// tb/tb_ppc_fetch_unit.sv - directed scoreboard bench for ppc_fetch_unit
// A bench memory model answers requests; expected instructions are queued when responses are driven.
module tb_ppc_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  logic clk;
  logic rst_n;
  ppc_fetch_unit_if bus ();

  ppc_fetch_unit #(
    .QDEPTH  (4),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          mem_lat;
  bit          mem_rdy;
  bit          ir;
  bit          redir_req;
  bit          arm_redir_resp;
  bit          pop_on_resp;
  bit          stray;
  logic [63:0] redir_addr;
  bit          busy;
  bit          stale;
  int          rem;
  logic [60:0] out_addr;
  logic [63:0] exp_pc;
  bit          accepted_now;
  bit          last_iv;
  int          pops;
  ent_t        sb[$];
  logic [60:0] acc_log[$];
  logic [63:0] pop_pc_log[$];
  logic [31:0] pop_w_log[$];

  function automatic logic [31:0] word_at(input logic [63:0] pc);
    if (pc == 64'h0) return 32'h3860_0041;
    else if (pc == 64'h4) return 32'h3800_0000;
    else return 32'hC000_0000 ^ pc[31:0];
  endfunction

  function automatic logic [63:0] mem_dword(input logic [60:0] a);
    logic [63:0] base;
    base = {a, 3'b000};
    return {word_at(base), word_at(base + 64'd4)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit   r;
    bit   due;
    bit   rv;
    bit   wasb;
    ent_t e;
    @(negedge clk);
    accepted_now = 0;
    wasb = busy;
    due  = busy && (rem == 1);
    r    = redir_req || (arm_redir_resp && due);
    last_iv = bus.inst_valid;
    bus.redirect_valid = r;
    bus.redirect_pc    = redir_addr;
    bus.inst_ready     = ir || ((pop_on_resp || arm_redir_resp) && due);
    bus.mem_req_ready  = mem_rdy;
    if (bus.inst_valid && bus.inst_ready && !r) begin
      pop_pc_log.push_back(bus.inst_pc);
      pop_w_log.push_back(bus.inst);
      pops++;
      chk("pop_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("inst_pc", bus.inst_pc, e.pc);
        chk("inst", 64'(bus.inst), 64'(e.w));
      end
    end
    rv = 0;
    if (busy) begin
      if (rem == 1) begin
        rv = 1;
        busy = 0;
        bus.mem_resp_data = mem_dword(out_addr);
        if (!stale && !r) begin
          sb.push_back({exp_pc, word_at(exp_pc)});
          exp_pc = exp_pc + 64'd4;
        end
      end else begin
        rem--;
      end
    end else if (stray) begin
      rv = 1;
      bus.mem_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
      stray = 0;
    end
    bus.mem_resp_valid = rv;
    if (bus.mem_req_valid && mem_rdy) begin
      chk("single_outstanding", 64'(wasb), 64'(0));
      chk("req_addr", 64'(bus.mem_req_addr), 64'(exp_pc[63:3]));
      acc_log.push_back(bus.mem_req_addr);
      out_addr = bus.mem_req_addr;
      busy = 1;
      stale = 0;
      rem = mem_lat;
      accepted_now = 1;
    end
    if (r) begin
      exp_pc = {redir_addr[63:2], 2'b00};
      sb.delete();
      if (busy) stale = 1;
      redir_req = 0;
      arm_redir_resp = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted_now && n < 30);
    if (!accepted_now) chk({tag, "_timeout"}, 64'(accepted_now), 64'(1));
  endtask

  task automatic do_reset(input int n, input bit stray_now);
    @(negedge clk);
    rst_n = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc    = '0;
    bus.mem_resp_valid = 0;
    bus.mem_resp_data  = '0;
    bus.inst_ready     = 0;
    bus.mem_req_ready  = 0;
    busy = 0; stale = 0; rem = 0;
    redir_req = 0; arm_redir_resp = 0; pop_on_resp = 0; stray = 0;
    exp_pc = RESET_PC;
    sb.delete(); acc_log.delete(); pop_pc_log.delete(); pop_w_log.delete();
    #1;
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
    chk("rst_req_addr", 64'(bus.mem_req_addr), 64'(0));
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
    chk("rst_inst", 64'(bus.inst), 64'(0));
    chk("rst_inst_pc", bus.inst_pc, 64'(0));
    repeat (n) @(negedge clk);
    rst_n = 1;
    if (stray_now) begin
      bus.mem_resp_valid = 1;
      bus.mem_resp_data  = 64'hFEED_FACE_CAFE_0001;
    end
  endtask

  initial begin
    int a0;
    int p0;
    clk = 0; rst_n = 0;
    checks = 0; errors = 0; pops = 0;
    mem_lat = 1; mem_rdy = 1; ir = 1; redir_addr = '0;

    // Straight-line fetch with a 1-cycle memory
    do_reset(3, 0);
    ticks(2);
    chk("first_req_by_edge2", 64'(acc_log.size() > 0), 64'(1));
    ticks(10);
    chk("s1_acc_count", 64'(acc_log.size() >= 3), 64'(1));
    chk("s1_addr0", 64'(acc_log[0]), 64'h0);
    chk("s1_addr1", 64'(acc_log[1]), 64'h0);
    chk("s1_addr2", 64'(acc_log[2]), 64'h1);
    chk("s1_pop_count", 64'(pop_pc_log.size() >= 2), 64'(1));
    chk("s1_inst0", 64'(pop_w_log[0]), 64'h3860_0041);
    chk("s1_pc1", pop_pc_log[1], 64'h4);
    chk("s1_inst1", 64'(pop_w_log[1]), 64'h3800_0000);

    // Backpressure fills exactly four entries, then drains in order
    do_reset(2, 0);
    ir = 0;
    ticks(12);
    chk("s2_req_idle", 64'(bus.mem_req_valid), 64'(0));
    chk("s2_full_valid", 64'(bus.inst_valid), 64'(1));
    chk("s2_head_pc", bus.inst_pc, 64'h0);
    chk("s2_acc_count", 64'(acc_log.size()), 64'(4));
    ir = 1;
    ticks(12);
    chk("s2_resume_seen", 64'(acc_log.size() >= 5), 64'(1));
    chk("s2_resume_addr", 64'(acc_log[4]), 64'h2);
    chk("s2_pc3", pop_pc_log[3], 64'hC);

    // Redirect while waiting on a 3-cycle response
    mem_lat = 3;
    wait_accept("s3_accept");
    a0 = acc_log.size();
    p0 = pop_pc_log.size();
    redir_addr = 64'h100;
    redir_req = 1;
    ticks(14);
    chk("s3_acc_seen", 64'(acc_log.size() > a0), 64'(1));
    chk("s3_new_addr", 64'(acc_log[a0]), 64'h20);
    chk("s3_pop_seen", 64'(pop_pc_log.size() > p0), 64'(1));
    chk("s3_first_pc", pop_pc_log[p0], 64'h100);

    // Redirect to 0x107 together with a response and a pop request
    ir = 0;
    ticks(12);
    p0 = pop_pc_log.size();
    redir_addr = 64'h107;
    arm_redir_resp = 1;
    for (int i = 0; i < 30 && arm_redir_resp; i++) tick();
    chk("s4_armed_fired", 64'(arm_redir_resp), 64'(0));
    arm_redir_resp = 0;
    chk("s4_valid_before", 64'(last_iv), 64'(1));
    chk("s4_no_pop", 64'(pop_pc_log.size()), 64'(p0));
    a0 = acc_log.size();
    tick();
    chk("s4_valid_after", 64'(last_iv), 64'(0));
    ir = 1;
    ticks(12);
    chk("s4_acc_seen", 64'(acc_log.size() > a0), 64'(1));
    chk("s4_new_addr", 64'(acc_log[a0]), 64'h20);
    chk("s4_pop_seen", 64'(pop_pc_log.size() > p0), 64'(1));
    chk("s4_first_pc", pop_pc_log[p0], 64'h104);

    // Near-full queue with pushes coinciding with pops
    mem_lat = 1;
    ir = 0;
    ticks(14);
    chk("s5_full_req_idle", 64'(bus.mem_req_valid), 64'(0));
    chk("s5_full_valid", 64'(bus.inst_valid), 64'(1));
    ir = 1;
    tick();
    ir = 0;
    pop_on_resp = 1;
    ticks(10);
    pop_on_resp = 0;
    ticks(6);
    chk("s5_refull_req_idle", 64'(bus.mem_req_valid), 64'(0));
    chk("s5_refull_valid", 64'(bus.inst_valid), 64'(1));
    mem_rdy = 0;
    ir = 1;
    p0 = pops;
    ticks(8);
    chk("s5_drain_count", 64'(pops - p0), 64'(4));
    chk("s5_empty", 64'(bus.inst_valid), 64'(0));
    chk("s5_sb_drained", 64'(sb.size()), 64'(0));
    mem_rdy = 1;

    // Reset during an outstanding request, then stray responses
    mem_lat = 3;
    wait_accept("s6_accept");
    tick();
    do_reset(2, 1);
    mem_rdy = 1; ir = 1; mem_lat = 1;
    stray = 1;
    ticks(12);
    chk("s6_acc_seen", 64'(acc_log.size() > 0), 64'(1));
    chk("s6_first_addr", 64'(acc_log[0]), 64'(RESET_PC[63:3]));
    chk("s6_pop_seen", 64'(pop_pc_log.size() > 0), 64'(1));
    chk("s6_first_pc", pop_pc_log[0], RESET_PC);
    chk("s6_first_inst", 64'(pop_w_log[0]), 64'(word_at(RESET_PC)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
